// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, iteration count.
package mdu_pkg;

    localparam int MDU_ITER = 32;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_SIGN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits. Purely combinational.
module mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_in, bit_in};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // The true difference always fits in WIDTH bits, so modular subtraction on the low word is exact.
    assign rem_out = shifted[WIDTH-1:0] - (q_bit ? divisor : '0);

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 34-cycle busy window per arithmetic op,
// MTHI/MTLO write in one cycle without leaving IDLE.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, neg_res, neg_dvd, div_zero;

    // Signed ops are the even encodings (MULT, DIV).
    logic             sa, sb;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign sa    = ~op[0] & a[WIDTH-1];
    assign sb    = ~op[0] & b[WIDTH-1];
    assign a_mag = sa ? -a : a;
    assign b_mag = sb ? -b : b;

    // acc = {partial product, remaining multiplier} for multiply,
    //       {partial remainder, dividend bits / quotient bits} for divide.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH-1:0]   rem_step;
    logic               q_step;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_in  (acc[2*WIDTH-1:WIDTH]),
        .bit_in  (acc[WIDTH-1]),
        .divisor (opnd),
        .rem_out (rem_step),
        .q_bit   (q_step)
    );
    assign div_next = {rem_step, acc[WIDTH-2:0], q_step};

    // A zero divisor leaves the dividend magnitude as remainder, so HI = a falls out naturally.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    assign prod_fix = neg_res ? -acc : acc;
    assign quot_fix = div_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign rem_fix  = neg_dvd ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_dvd  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (op <= MDU_DIVU) begin
                            is_div   <= op[1];
                            neg_res  <= sa ^ sb;
                            neg_dvd  <= sa;
                            div_zero <= (b == '0);
                            cnt      <= '0;
                            busy     <= 1'b1;
                            state    <= ST_CALC;
                            if (op[1]) begin
                                acc  <= {{WIDTH{1'b0}}, a_mag};
                                opnd <= b_mag;
                            end else begin
                                acc  <= {{WIDTH{1'b0}}, b_mag};
                                opnd <= a_mag;
                            end
                        end else if (op == MDU_MTHI) begin
                            hi <= a;
                        end else if (op == MDU_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                ST_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= ST_SIGN;
                end
                ST_SIGN: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, randomized ops against an arithmetic model,
// and hand-written reset / busy-start / MTHI-MTLO sequences.
module tb_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] t, tq;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin
                t = sx * sy;
                return t;
            end
            3'd1: return {32'b0, x} * {32'b0, y};
            3'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q  = sx / sy;
                r  = sx % sy;
                t  = r;
                tq = q;
                return {t[31:0], tq[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Issue one arithmetic op, check busy/done timing, return HI/LO seen in the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string tag, output logic [31:0] rh, output logic [31:0] rl);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        check($sformatf("%s busy", tag), busy, 1);
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s done seen", tag), done, 1);
        check($sformatf("%s latency", tag), cyc, 34);
        check($sformatf("%s busy at done", tag), busy, 1);
        rh = hi;
        rl = lo;
        @(negedge clk);
        check($sformatf("%s done width", tag), done, 0);
        check($sformatf("%s idle after", tag), busy, 0);
        check($sformatf("%s hold", tag), {hi, lo}, {rh, rl});
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] rh, rl;
        logic [63:0] exp;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          ndone;

        vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3,          32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd3, 32'd7,         32'd2,          32'd1,         32'd3};
        vecs[4] = '{3'd2, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF};
        vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
        vecs[6] = '{3'd3, 32'hFFFF_FFFF, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0};

        #2;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), rh, rl);
            check($sformatf("vec%0d hi", i), rh, vecs[i].ehi);
            check($sformatf("vec%0d lo", i), rl, vecs[i].elo);
        end

        // Reset in the middle of CALC must discard the op and clear HI/LO immediately.
        @(negedge clk); start = 1'b1; op = 3'd4; a = 32'hAAAA;
        @(negedge clk); op = 3'd5; a = 32'h5555;
        @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd7;
        check("preload hi", hi, 32'hAAAA);
        check("preload lo", lo, 32'h5555);
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset hi", hi, 0);
        check("midreset lo", lo, 0);
        @(negedge clk); rstn = 1'b1;
        run_op(3'd1, 32'd5, 32'd7, "post-reset multu", rh, rl);
        check("post-reset hi", rh, 0);
        check("post-reset lo", rl, 35);

        // Starts while busy are ignored; exactly one done pulse.
        @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        ndone = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 5 || i == 20) begin
                start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) ndone++;
        end
        check("busy-start done count", ndone, 1);
        check("busy-start hi", hi, 32'd2);
        check("busy-start lo", lo, 32'd14);
        check("busy-start idle", busy, 0);

        // Back-to-back MTHI / MTLO.
        @(negedge clk); start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
        @(negedge clk); op = 3'd5; a = 32'h1;
        check("mthi hi", hi, 32'hDEAD_BEEF);
        check("mthi busy", busy, 0);
        check("mthi done", done, 0);
        @(negedge clk); start = 1'b1; op = 3'd6; a = 32'h7777;
        check("mtlo lo", lo, 32'h1);
        check("mtlo hi kept", hi, 32'hDEAD_BEEF);
        check("mtlo busy", busy, 0);
        @(negedge clk); start = 1'b0;
        check("noop hi", hi, 32'hDEAD_BEEF);
        check("noop lo", lo, 32'h1);
        check("noop busy", busy, 0);
        check("noop done", done, 0);

        // Randomized ops against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            exp = model(ro, ra, rb);
            run_op(ro, ra, rb, $sformatf("rand%0d", i), rh, rl);
            check($sformatf("rand%0d op%0d a=%h b=%h hi", i, ro, ra, rb), rh, exp[63:32]);
            check($sformatf("rand%0d op%0d a=%h b=%h lo", i, ro, ra, rb), rl, exp[31:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit owning the HI/LO pair, sitting directly downstream of the register file in the execute stage. It consumes the two register read ports (RD1 → `a`, RD2 → `b`), runs MULT/MULTU/DIV/DIVU over 32 iterations, and exposes HI/LO so MFHI/MFLO results return to the register file write-data mux. The controller stalls on `busy`.

## Interface
- `WIDTH`, 32: operand and HI/LO width; iteration count equals `WIDTH`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6–7=no-op.
- `a`  in  WIDTH  rs operand (register file RD1).
- `b`  in  WIDTH  rt operand (register file RD2).
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when HI/LO are updated by an arithmetic op.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE + `start` + op 0–3: latch magnitudes of `a`/`b` (absolute values for MULT/DIV, raw for unsigned), latch result-sign flags, clear iteration counter → CALC.
- IDLE + `start` + MTHI/MTLO: `hi`/`lo` ← `a` at that edge; stays IDLE; no `busy`, no `done`.
- IDLE + `start` + op 6–7: ignored.
- CALC: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle; counter 0..WIDTH-1; at counter = WIDTH-1 → SIGN.
- SIGN: apply signs. MULT: negate 64-bit product if signs differ. DIV: quotient negated if signs differ; remainder takes sign of dividend. `hi`/`lo` written at SIGN→DONE edge.
- DONE: `done`=1 for this cycle; → IDLE.
- `start` outside IDLE ignored; operands not re-sampled.
- Divide by zero: LO = all ones, HI = dividend (unmodified `a`), signed or unsigned; full latency still applies.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Products: MULT/MULTU give full 64-bit result, HI = upper word, LO = lower word; no overflow.
- `hi`/`lo` hold value except at MTHI/MTLO or SIGN→DONE edges.

## Timing
- Reset (async, any state including mid-CALC): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0; in-flight op discarded.
- `start` sampled at edge E0 → `busy` high after E0.
- CALC occupies edges E1..E32; SIGN at E33 writes HI/LO; DONE cycle follows E33 (`done`=1); IDLE after E34.
- `busy` high for 34 cycles; new `start` accepted at E34 earliest.
- HI/LO readable with new value the cycle after E33 (same cycle as `done`).
- MTHI/MTLO: value visible the cycle after the sampling edge.
- Register file writes on falling edge; MFHI/MFLO results routed from `hi`/`lo` are stable a full half-cycle before that write.

## Structure
- Package `mdu_pkg`: op encodings (`MDU_MULT`…`MDU_MTLO`), state encoding, `MDU_ITER = 32`.
- Sub-module `mdu_divstep`: combinational single restoring-division step (partial remainder, divisor → next remainder, quotient bit); instantiated once in the CALC datapath.
- Multiply step, sign fix and FSM stay in `mdu`.

## Test plan
- Reset mid-op: start MULTU 5×7, drop `rstn` at cycle 10 → `busy`=0, `hi`=`lo`=0 immediately; new MULTU 5×7 later → `lo`=35, `hi`=0, `done` after 34 cycles.
- MULT 0xFFFFFFFE × 3 (−2×3) → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA; MULTU same operands → `hi`=2, `lo`=0xFFFFFFFA.
- DIV −7 / 2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1); DIVU 7/2 → `lo`=3, `hi`=1.
- DIV by zero: `a`=0x1234, `b`=0 → `lo`=0xFFFFFFFF, `hi`=0x1234; DIV 0x80000000/−1 → `lo`=0x80000000, `hi`=0.
- `start` with different operands while busy → ignored; first result unchanged; `done` pulses exactly once, 1 cycle wide.
- MTHI 0xDEADBEEF then MTLO 0x1 on consecutive cycles → `hi`/`lo` updated next cycle, `busy`/`done` never asserted.
